dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter N, default 32: data and address word width.
REQ-002 Parameter WORDS, default 128: data memory depth. Addresses at or above WORDS are out of range.
REQ-003 CLK  in  1: single clock. All state changes on the rising edge.
REQ-004 RESET_N  in  1: asynchronous, active-low reset.
REQ-005 REQ  in  5: access request per requester. Bit 0 is the security controller (SC); bits 1-4 are IP1-IP4.
REQ-006 WE  in  5: per requester, 1 = write, 0 = read. Qualified by REQ.
REQ-007 ADDR  in  5*N: packed per-requester address; requester k occupies bits [k*N +: N].
REQ-008 WDATA  in  5*N: packed per-requester write data, same packing as ADDR.
REQ-009 DIS  in  4: DIS[k-1]=1 disables IPk. Sourced from status word 20.
REQ-010 GNT  out  5: one-hot, one-cycle pulse; the request is consumed.
REQ-011 ERR  out  5: one-cycle pulse, asserted together with GNT, when the access was refused.
REQ-012 RVALID  out  5: one-cycle pulse; RDATA is valid for that requester.
REQ-013 RDATA  out  N: read data, shared by all requesters.
REQ-014 MADDR, MDOUT  out  N each: memory address and memory write data.
REQ-015 MWRITE, MREAD  out  1 each: memory strobes; never both 1 at once.
REQ-016 MDIN  in  N: memory read data, combinational from MADDR.

Function
REQ-017 The FSM shall have four states: IDLE, WRITE, READ, RESP; encoding 2'b00-2'b11.
REQ-018 In IDLE with any REQ bit set, the arbiter shall pick winner w by round-robin, searching upward from pointer PTR (0-4) with wrap from 4 to 0.
REQ-019 On the next edge after a pick, PTR shall load (w+1) mod 5.
REQ-020 Legality: SC may access any address below WORDS. IPk may access only 48+16(k-1) through 63+16(k-1), and only when DIS[k-1]=0.
REQ-021 An illegal winner shall go IDLE->IDLE.
- GNT[w] and ERR[w] pulse in the following cycle.
- No memory strobe is asserted.
- No RVALID is generated.
REQ-022 A legal write shall go IDLE->WRITE for exactly one cycle.
- In that cycle: MWRITE=1, MADDR=ADDR[w], MDOUT=WDATA[w], GNT[w]=1.
- Then return to IDLE.
REQ-023 A legal read shall go IDLE->READ->RESP.
- In READ: MREAD=1, MADDR=ADDR[w], GNT[w]=1; RDATA is registered from MDIN at the end of READ.
- In RESP: RVALID[w]=1 and RDATA holds the read word.
- Then return to IDLE.
REQ-024 Latency from REQ sampled in IDLE:
- Write: memory write in cycle +1.
- Read: data valid in cycle +2.
- Minimum spacing between grants: 2 cycles for writes, 3 cycles for reads.
REQ-025 Requesters shall hold REQ, WE, ADDR and WDATA stable until GNT. The arbiter samples ADDR, WE, WDATA and DIS only in IDLE and registers them for the transaction.
REQ-026 Deasserting REQ before GNT shall withdraw the request with no side effects.
- A DIS change after the IDLE sample shall not abort the transaction in flight.
REQ-027 Outside the WRITE and READ states, MWRITE=MREAD=0 and MADDR=MDOUT=0.
REQ-028 RDATA shall hold its last value until the next RESP.
REQ-029 At most one bit each of GNT, ERR and RVALID shall be set in any cycle.

Reset
REQ-030 When RESET_N=0, the block shall, immediately and independently of CLK:
- set state=IDLE and PTR=0;
- set GNT, ERR, RVALID, MWRITE, MREAD=0;
- set RDATA, MADDR, MDOUT=0.
REQ-031 Reset asserted during WRITE, READ or RESP shall abandon the transaction; no RVALID or GNT shall follow after release.
REQ-032 The first IDLE evaluation shall occur on the first rising CLK edge after RESET_N rises.

Verification
REQ-033 SC write: REQ=5'b00001, WE[0]=1, ADDR=20, WDATA=32'h0000_8A03.
- Response: one cycle with MWRITE=1, MADDR=20, MDOUT=32'h8A03, GNT=5'b00001.
- No ERR.
REQ-034 IP2 read: REQ[2]=1, WE[2]=0, ADDR=70, MDIN=32'hDEAD_BEEF at address 70.
- Response: MREAD=1 in cycle +1, then RVALID=5'b00100 and RDATA=32'hDEADBEEF in cycle +2.
REQ-035 All five requesters write, held from reset.
- Grant order: 0,1,2,3,4,0, with each GNT 2 cycles apart.
REQ-036 IP3 writes ADDR=40 (outside 80-95), then DIS=4'b1000 with IP4 writing ADDR=100.
- Response: ERR[3] with GNT[3], then ERR[4] with GNT[4].
- MWRITE stays 0 throughout.
REQ-037 RESET_N pulled low in a READ cycle.
- Response: MREAD=0 immediately.
- No RVALID after release.
- The next grant starts from PTR=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every signal between the data-memory arbiter and the outside world:
// the five requesters (SC plus IP1-IP4), the disable word, and the single-port
// data memory.
//
//   req[4:0]      request per requester (bit 0 = SC, bits 1-4 = IP1-IP4)
//   we[4:0]       1 = write, 0 = read, qualified by req
//   addr, wdata   packed per-requester address / write data, k at [k*N +: N]
//   dis[3:0]      dis[k-1] = 1 disables IPk
//   gnt, err      one-hot pulses: request consumed / request refused
//   rvalid        one-hot pulse: rdata valid for that requester
//   rdata         shared read data
//   maddr, mdout  memory address / write data
//   mwrite, mread memory strobes
//   mdin          memory read data, combinational from maddr
//
// Modports: slave = arbiter side, master = requesters + memory side.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int N = 32
);
  logic [4:0]     req;
  logic [4:0]     we;
  logic [5*N-1:0] addr;
  logic [5*N-1:0] wdata;
  logic [3:0]     dis;
  logic [4:0]     gnt;
  logic [4:0]     err;
  logic [4:0]     rvalid;
  logic [N-1:0]   rdata;
  logic [N-1:0]   maddr;
  logic [N-1:0]   mdout;
  logic           mwrite;
  logic           mread;
  logic [N-1:0]   mdin;

  modport slave (
    input  req, we, addr, wdata, dis, mdin,
    output gnt, err, rvalid, rdata, maddr, mdout, mwrite, mread
  );

  modport master (
    output req, we, addr, wdata, dis, mdin,
    input  gnt, err, rvalid, rdata, maddr, mdout, mwrite, mread
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Round-robin arbiter giving five requesters (security controller SC and
// IP1-IP4) access to a single-port data memory, with per-requester address
// windows and IP disable bits.
//
// Ports:
//   clk      single clock, all state changes on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      dmem_arbiter_if.slave (requests, grants, responses, memory port)
//
// Transaction flow (one transaction at a time):
//   IDLE  --pick, refused-->  IDLE   (gnt+err pulse next cycle)
//   IDLE  --pick, write-->    WRITE  (one cycle with mwrite, gnt)
//   IDLE  --pick, read-->     READ   (mread, gnt; rdata captured at its end)
//   READ  -->                 RESP   (rvalid)
// All outputs are registered, so the cycle after a pick carries the grant.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int N     = 32,
  parameter int WORDS = 128
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t       state_reg, state_next;
  logic [2:0]   ptr_reg, ptr_next;
  logic [2:0]   win_reg, win_next;
  logic [4:0]   gnt_reg, gnt_next;
  logic [4:0]   err_reg, err_next;
  logic [4:0]   rvalid_reg, rvalid_next;
  logic         mwrite_reg, mwrite_next;
  logic         mread_reg, mread_next;
  logic [N-1:0] maddr_reg, maddr_next;
  logic [N-1:0] mdout_reg, mdout_next;
  logic [N-1:0] rdata_reg;

  // Per-requester views, padded to 8 entries so a 3-bit index never leaves
  // the array.
  logic [N-1:0] addr_arr  [8];
  logic [N-1:0] wdata_arr [8];
  logic [7:0]   we_vec;
  logic [7:0]   legal_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_req
      if (gi < 5) begin : g_live
        // Address window; capped at the memory depth so nothing at or above
        // WORDS is ever legal.
        localparam int LO_RAW = (gi == 0) ? 0 : 48 + 16 * (gi - 1);
        localparam int HI_RAW = (gi == 0) ? WORDS - 1 : 63 + 16 * (gi - 1);
        localparam int HI     = (HI_RAW < WORDS) ? HI_RAW : WORDS - 1;
        localparam logic [N-1:0] LO_W = N'(LO_RAW);
        localparam logic [N-1:0] HI_W = N'(HI);

        assign addr_arr[gi]  = bus.addr[gi*N +: N];
        assign wdata_arr[gi] = bus.wdata[gi*N +: N];
        assign we_vec[gi]    = bus.we[gi];

        if (gi == 0) begin : g_sc
          assign legal_vec[gi] = (addr_arr[gi] <= HI_W);
        end else begin : g_ip
          assign legal_vec[gi] = (addr_arr[gi] >= LO_W) &&
                                 (addr_arr[gi] <= HI_W) &&
                                 !bus.dis[gi-1];
        end
      end else begin : g_pad
        assign addr_arr[gi]  = '0;
        assign wdata_arr[gi] = '0;
        assign we_vec[gi]    = 1'b0;
        assign legal_vec[gi] = 1'b0;
      end
    end
  endgenerate

  // Round-robin pick: rotate the request vector so that bit 0 is the
  // requester at ptr, find the lowest set bit, then rotate the offset back.
  logic [14:0] req_dbl;
  logic [4:0]  req_rot;
  logic [2:0]  pick_off;
  logic [3:0]  pick_sum;
  logic [2:0]  pick;
  logic [4:0]  pick_oh;

  assign req_dbl = {bus.req, bus.req, bus.req};
  assign req_rot = req_dbl[ptr_reg +: 5];

  always_comb begin
    pick_off = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (req_rot[i]) pick_off = 3'(i);
    end
  end

  assign pick_sum = {1'b0, ptr_reg} + {1'b0, pick_off};
  assign pick     = (pick_sum >= 4'd5) ? 3'(pick_sum - 4'd5) : pick_sum[2:0];
  assign pick_oh  = 5'd1 << pick;

  // Next-state and next-output logic
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    win_next    = win_reg;
    gnt_next    = '0;
    err_next    = '0;
    rvalid_next = '0;
    mwrite_next = 1'b0;
    mread_next  = 1'b0;
    maddr_next  = '0;
    mdout_next  = '0;

    case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          ptr_next = (pick == 3'd4) ? 3'd0 : pick + 3'd1;
          win_next = pick;
          gnt_next = pick_oh;
          if (!legal_vec[pick]) begin
            err_next = pick_oh;
          end else if (we_vec[pick]) begin
            state_next  = WRITE;
            mwrite_next = 1'b1;
            maddr_next  = addr_arr[pick];
            mdout_next  = wdata_arr[pick];
          end else begin
            state_next = READ;
            mread_next = 1'b1;
            maddr_next = addr_arr[pick];
          end
        end
      end
      WRITE: state_next = IDLE;
      READ: begin
        state_next  = RESP;
        rvalid_next = 5'd1 << win_reg;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= 3'd0;
      win_reg    <= 3'd0;
      gnt_reg    <= '0;
      err_reg    <= '0;
      rvalid_reg <= '0;
      mwrite_reg <= 1'b0;
      mread_reg  <= 1'b0;
      maddr_reg  <= '0;
      mdout_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      win_reg    <= win_next;
      gnt_reg    <= gnt_next;
      err_reg    <= err_next;
      rvalid_reg <= rvalid_next;
      mwrite_reg <= mwrite_next;
      mread_reg  <= mread_next;
      maddr_reg  <= maddr_next;
      mdout_reg  <= mdout_next;
    end
  end

  // Read data is captured at the end of READ and held until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_reg <= '0;
    end else if (state_reg == READ) begin
      rdata_reg <= bus.mdin;
    end
  end

  assign bus.gnt    = gnt_reg;
  assign bus.err    = err_reg;
  assign bus.rvalid = rvalid_reg;
  assign bus.rdata  = rdata_reg;
  assign bus.maddr  = maddr_reg;
  assign bus.mdout  = mdout_reg;
  assign bus.mwrite = mwrite_reg;
  assign bus.mread  = mread_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios followed by randomized request traffic, checked against a
// transaction-level reference model (round-robin scan, address-window rules,
// reference memory array). Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int N     = 32;
  localparam int WORDS = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.N(N)) bif ();

  dmem_arbiter #(.N(N), .WORDS(WORDS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  // Environment memory: combinational read, written on mwrite, preloadable.
  logic [N-1:0] mem [WORDS];
  logic         pl_en = 1'b0;
  logic [6:0]   pl_addr = '0;
  logic [N-1:0] pl_data = '0;

  assign bif.mdin = (bif.maddr < WORDS) ? mem[bif.maddr[6:0]] : '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bif.mwrite && bif.maddr < WORDS) mem[bif.maddr[6:0]] <= bif.mdout;
  end

  // Reference model state
  logic [N-1:0] ref_mem [WORDS];
  int           model_ptr;
  logic [N-1:0] a_arr  [5];
  logic [N-1:0] wd_arr [5];
  logic [4:0]   we_v;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input int p, input logic [4:0] r);
    for (int i = 0; i < 5; i++) begin
      int k;
      k = (p + i) % 5;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit legal_f(input int k, input logic [N-1:0] a, input logic [3:0] d);
    int lo;
    if (k == 0) return (a < WORDS);
    lo = 48 + 16 * (k - 1);
    return (a >= lo) && (a <= lo + 15) && (a < WORDS) && !d[k-1];
  endfunction

  task automatic drive_bus();
    for (int k = 0; k < 5; k++) begin
      bif.addr[k*N +: N]  = a_arr[k];
      bif.wdata[k*N +: N] = wd_arr[k];
    end
    bif.we = we_v;
  endtask

  task automatic set_req(input int k, input bit we, input logic [N-1:0] a, input logic [N-1:0] wd);
    a_arr[k] = a; wd_arr[k] = wd; we_v[k] = we;
    bif.req[k] = 1'b1;
    drive_bus();
  endtask

  // Called at a falling edge; asserts reset, checks the async clear, releases
  // at a later falling edge so the next rising edge is the first evaluation.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_gnt", bif.gnt, 0);
    chk("rst_err", bif.err, 0);
    chk("rst_rvalid", bif.rvalid, 0);
    chk("rst_strobes", {bif.mwrite, bif.mread}, 0);
    chk("rst_maddr", bif.maddr, 0);
    chk("rst_mdout", bif.mdout, 0);
    chk("rst_rdata", bif.rdata, 0);
    model_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One arbitration opportunity. Entered at a falling edge with the arbiter
  // idle; returns at the falling edge before its next evaluation.
  task automatic step(input bit chaos_dis);
    int           w;
    bit           lg;
    bit           wr;
    logic [4:0]   oh;
    logic [N-1:0] a;
    logic [N-1:0] wd;
    logic [N-1:0] exp_rd;
    if (bif.req == 5'b0) begin
      @(negedge clk);
      chk("idle_gnt", bif.gnt, 0);
      chk("idle_strobes", {bif.mwrite, bif.mread}, 0);
      return;
    end
    w  = rr(model_ptr, bif.req);
    a  = a_arr[w];
    wd = wd_arr[w];
    wr = we_v[w];
    lg = legal_f(w, a, bif.dis);
    oh = 5'd1 << w;
    model_ptr = (w + 1) % 5;
    @(negedge clk);
    chk("gnt", bif.gnt, oh);
    chk("err", bif.err, lg ? 5'd0 : oh);
    chk("mwrite", bif.mwrite, lg && wr);
    chk("mread", bif.mread, lg && !wr);
    chk("maddr", bif.maddr, lg ? a : '0);
    chk("mdout", bif.mdout, (lg && wr) ? wd : '0);
    chk("rvalid_at_gnt", bif.rvalid, 0);
    bif.req[w] = 1'b0;
    if (chaos_dis) bif.dis = 4'($urandom);
    if (!lg) return;
    if (wr) begin
      ref_mem[a[6:0]] = wd;
      @(negedge clk);
      chk("post_wr_gnt", bif.gnt, 0);
      chk("post_wr_strobes", {bif.mwrite, bif.mread}, 0);
      chk("post_wr_maddr", bif.maddr, 0);
    end else begin
      exp_rd = ref_mem[a[6:0]];
      @(negedge clk);
      chk("rvalid", bif.rvalid, oh);
      chk("rdata", bif.rdata, exp_rd);
      chk("resp_gnt", bif.gnt, 0);
      chk("resp_strobes", {bif.mwrite, bif.mread}, 0);
      @(negedge clk);
      chk("post_resp_rvalid", bif.rvalid, 0);
      chk("rdata_hold", bif.rdata, exp_rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.req = '0; bif.dis = '0; we_v = '0;
    for (int k = 0; k < 5; k++) begin a_arr[k] = '0; wd_arr[k] = '0; end
    drive_bus();
    model_ptr = 0;

    // Preload memory and reference copy while held in reset
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      pl_en = 1'b1;
      pl_addr = 7'(i);
      pl_data = (i == 70) ? 32'hDEAD_BEEF : (32'hA500_0000 ^ (i * 32'h0101_0101));
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
    do_reset();

    // SC write to address 20
    set_req(0, 1'b1, 32'd20, 32'h0000_8A03);
    step(1'b0);

    // IP2 read from address 70
    set_req(2, 1'b0, 32'd70, 32'h0);
    step(1'b0);
    chk("ip2_rdata_const", bif.rdata, 32'hDEAD_BEEF);

    // All five requesters write, held through reset
    set_req(0, 1'b1, 32'd21, 32'h1111_0000);
    set_req(1, 1'b1, 32'd48, 32'h1111_0001);
    set_req(2, 1'b1, 32'd64, 32'h1111_0002);
    set_req(3, 1'b1, 32'd80, 32'h1111_0003);
    set_req(4, 1'b1, 32'd96, 32'h1111_0004);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0);
    set_req(0, 1'b1, 32'd22, 32'h1111_0010);
    step(1'b0);

    // IP3 outside its window, then IP4 disabled
    set_req(3, 1'b1, 32'd40, 32'h3333_3333);
    step(1'b0);
    bif.dis = 4'b1000;
    set_req(4, 1'b1, 32'd100, 32'h4444_4444);
    step(1'b0);

    // Reset during READ
    set_req(0, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    chk("pre_rst_mread", bif.mread, 1'b1);
    bif.req = '0;
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("after_rst_rvalid", bif.rvalid, 0);
      chk("after_rst_gnt", bif.gnt, 0);
    end
    set_req(0, 1'b1, 32'd3, 32'h5555_0000);
    set_req(1, 1'b1, 32'd50, 32'h5555_0001);
    step(1'b0);
    step(1'b0);

    // Randomized traffic
    bif.dis = '0;
    for (int it = 0; it < 400; it++) begin
      if ($urandom % 5 == 0) bif.dis = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
      for (int k = 0; k < 5; k++) begin
        if (!bif.req[k] && ($urandom % 3 == 0)) begin
          int mode;
          int rk;
          logic [N-1:0] ra;
          mode = $urandom % 4;
          rk = (mode == 3) ? int'($urandom % 5) : k;
          if (mode == 2) ra = $urandom % 160;
          else if (rk == 0) ra = $urandom % WORDS;
          else ra = 48 + 16 * (rk - 1) + ($urandom % 16);
          set_req(k, 1'($urandom % 2), ra, $urandom);
        end
      end
      if ($urandom % 10 == 0) bif.req[$urandom % 5] = 1'b0;
      step(1'($urandom % 4 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
